// File: rtl/ioq_header_inserter_pkg.sv
// Shared IOQ header layout constants, common to the header inserter and the
// IOQ header parser, plus the inserter's FSM state type.
package ioq_header_inserter_pkg;

  // ctrl value that tags a word as the IOQ module header
  localparam int IO_QUEUE_STAGE_NUM = 8'hff;

  // Bit positions of the fields inside the 64-bit IOQ header word
  localparam int IOQ_BYTE_LEN_POS = 0;
  localparam int IOQ_SRC_PORT_POS = 16;
  localparam int IOQ_WORD_LEN_POS = 32;
  localparam int IOQ_DST_PORT_POS = 48;

  // The destination field is a 16-bit one-hot port map
  localparam int IOQ_DST_PORT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } ioq_state_e;

endpackage

// File: rtl/ioq_header_inserter_fifo.sv
// Small first-word-fallthrough FIFO: dout always shows the head entry while
// the FIFO is non-empty. Writes into a full FIFO are discarded.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      do_wr;
  logic                      do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign full  = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
  assign empty = (depth == '0);
  assign dout  = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   depth <= depth + (MAX_DEPTH_BITS+1)'(1);
        2'b01:   depth <= depth - (MAX_DEPTH_BITS+1)'(1);
        default: depth <= depth;
      endcase
    end
  end

endmodule

// File: rtl/ioq_header_inserter.sv
// Prepends an IOQ module header word to each packet, built from a queued
// descriptor, and flags packets whose payload word count disagrees with the
// descriptor byte length.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | between packets; waits for a descriptor and out_rdy
// ST_HDR     | header word is on the output (out_wr=1), input held off
// ST_PAYLOAD | payload words pass through one cycle late until EOP
module ioq_header_inserter
  import ioq_header_inserter_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int IOQ_STAGE_NUM      = IO_QUEUE_STAGE_NUM,
  parameter int NUM_OUTPUT_QUEUES  = 8,
  parameter int NUM_OQ_WIDTH       = $clog2(NUM_OUTPUT_QUEUES),
  parameter int PKT_BYTE_CNT_WIDTH = 11,
  parameter int PKT_WORD_CNT_WIDTH = 8,
  parameter int PKT_SRC_PORT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          desc_wr,
  input  logic [NUM_OQ_WIDTH-1:0]       desc_dst_oq,
  input  logic [PKT_BYTE_CNT_WIDTH-1:0] desc_byte_len,
  input  logic [PKT_SRC_PORT_WIDTH-1:0] desc_src_port,
  output logic                          desc_rdy,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [CTRL_WIDTH-1:0]         in_ctrl,
  input  logic                          in_wr,
  output logic                          in_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CTRL_WIDTH-1:0]         out_ctrl,
  output logic                          out_wr,
  input  logic                          out_rdy,
  output logic                          len_err
);

  localparam int DESC_W = NUM_OQ_WIDTH + PKT_BYTE_CNT_WIDTH + PKT_SRC_PORT_WIDTH;

  ioq_state_e                    state;
  ioq_state_e                    state_nxt;
  logic [DESC_W-1:0]             fifo_din;
  logic [DESC_W-1:0]             fifo_dout;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_rd;
  logic [NUM_OQ_WIDTH-1:0]       hd_dst;
  logic [PKT_BYTE_CNT_WIDTH-1:0] hd_len;
  logic [PKT_SRC_PORT_WIDTH-1:0] hd_src;
  logic [PKT_BYTE_CNT_WIDTH:0]   len_plus;
  logic [PKT_WORD_CNT_WIDTH-1:0] hd_words;
  logic [IOQ_DST_PORT_WIDTH-1:0] hd_dst_1hot;
  logic [DATA_WIDTH-1:0]         hdr_word;
  logic                          accept;
  logic                          is_eop;
  logic [PKT_WORD_CNT_WIDTH-1:0] word_cnt;
  logic [PKT_WORD_CNT_WIDTH-1:0] cnt_inc;
  logic [PKT_WORD_CNT_WIDTH-1:0] pkt_words;

  assign fifo_din = {desc_dst_oq, desc_byte_len, desc_src_port};
  assign desc_rdy = ~fifo_full;

  fallthrough_small_fifo #(
    .WIDTH          (DESC_W),
    .MAX_DEPTH_BITS (2)
  ) u_desc_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (fifo_din),
    .wr_en (desc_wr),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {hd_dst, hd_len, hd_src} = fifo_dout;

  // Word length rounds the byte count up to whole 8-byte words, then truncates
  assign len_plus = {1'b0, hd_len} + (PKT_BYTE_CNT_WIDTH+1)'(7);
  assign hd_words = PKT_WORD_CNT_WIDTH'(len_plus >> 3);

  // One-hot destination; queue numbers beyond the configured count map to 0
  always_comb begin
    hd_dst_1hot = '0;
    for (int i = 0; i < IOQ_DST_PORT_WIDTH; i++) begin
      if (i < NUM_OUTPUT_QUEUES && i == int'(hd_dst)) begin
        hd_dst_1hot[i] = 1'b1;
      end
    end
  end

  // Assemble the header word from the descriptor at the FIFO head
  always_comb begin
    hdr_word = '0;
    hdr_word[IOQ_BYTE_LEN_POS +: PKT_BYTE_CNT_WIDTH] = hd_len;
    hdr_word[IOQ_SRC_PORT_POS +: PKT_SRC_PORT_WIDTH] = hd_src;
    hdr_word[IOQ_WORD_LEN_POS +: PKT_WORD_CNT_WIDTH] = hd_words;
    hdr_word[IOQ_DST_PORT_POS +: IOQ_DST_PORT_WIDTH] = hd_dst_1hot;
  end

  // Input is only taken mid-packet, and only when the output can take it next
  assign in_rdy  = (state == ST_PAYLOAD) && out_rdy && !reset;
  assign accept  = in_wr && in_rdy;
  assign is_eop  = (in_ctrl != '0);
  assign cnt_inc = word_cnt + PKT_WORD_CNT_WIDTH'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and descriptor pop (the pop coincides with header registration)
  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && out_rdy) begin
          fifo_rd   = 1'b1;
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (accept && is_eop) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output register: header on the pop cycle, otherwise the accepted word;
  // the length check fires alongside the EOP word
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_ctrl  <= '0;
      out_wr    <= 1'b0;
      len_err   <= 1'b0;
      word_cnt  <= '0;
      pkt_words <= '0;
    end else begin
      out_wr  <= 1'b0;
      len_err <= 1'b0;
      if (fifo_rd) begin
        out_data  <= hdr_word;
        out_ctrl  <= CTRL_WIDTH'(IOQ_STAGE_NUM);
        out_wr    <= 1'b1;
        word_cnt  <= '0;
        pkt_words <= hd_words;
      end else if (accept) begin
        out_data <= in_data;
        out_ctrl <= in_ctrl;
        out_wr   <= 1'b1;
        word_cnt <= cnt_inc;
        if (is_eop && (cnt_inc != pkt_words)) begin
          len_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ioq_header_inserter.sv
// Bench for ioq_header_inserter: directed packets plus random ones, checked
// against a packet-level model (descriptor queue + expected word stream).
module tb_ioq_header_inserter;
  import ioq_header_inserter_pkg::*;

  localparam int NQ = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        desc_wr;
  logic [2:0]  desc_dst_oq;
  logic [10:0] desc_byte_len;
  logic [15:0] desc_src_port;
  logic        desc_rdy;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        len_err;

  always #5 clk = ~clk;

  ioq_header_inserter #(
    .NUM_OUTPUT_QUEUES (NQ)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .desc_wr       (desc_wr),
    .desc_dst_oq   (desc_dst_oq),
    .desc_byte_len (desc_byte_len),
    .desc_src_port (desc_src_port),
    .desc_rdy      (desc_rdy),
    .in_data       (in_data),
    .in_ctrl       (in_ctrl),
    .in_wr         (in_wr),
    .in_rdy        (in_rdy),
    .out_data      (out_data),
    .out_ctrl      (out_ctrl),
    .out_wr        (out_wr),
    .out_rdy       (out_rdy),
    .len_err       (len_err)
  );

  typedef struct {
    logic [2:0]  oq;
    logic [10:0] len;
    logic [15:0] src;
  } desc_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        err;
  } word_t;

  int     total = 0;
  int     bad = 0;
  desc_t  pending[$];
  word_t  exp_q[$];
  bit     in_pkt = 0;
  int     hdr_age = 0;
  int     pkt_cnt = 0;
  int     pkt_words = 0;
  bit     last_acc = 0;

  function automatic int words_of(input desc_t d);
    return ((int'(d.len) + 7) / 8) % 256;
  endfunction

  function automatic logic [63:0] hdr_of(input desc_t d);
    logic [63:0] h;
    h = 64'(d.len);
    h = h | (64'(d.src) << 16);
    h = h | (64'(words_of(d)) << 32);
    if (int'(d.oq) < NQ) h = h | (64'(1) << (48 + int'(d.oq)));
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: pre-edge handshake checks, edge, then output checks vs model
  task automatic step();
    bit          acc;
    bit          dacc;
    logic        rdy_at_edge;
    desc_t       d;
    word_t       w;
    logic [63:0] wd;
    logic [7:0]  wc;
    #1;
    chk("in_rdy", 64'(in_rdy), (in_pkt && hdr_age >= 1 && !reset) ? 64'(out_rdy) : 64'(0));
    chk("desc_rdy", 64'(desc_rdy), 64'(pending.size() < 4));
    acc = in_wr && in_pkt && (hdr_age >= 1) && out_rdy && !reset;
    dacc = desc_wr && (pending.size() < 4) && !reset;
    rdy_at_edge = out_rdy;
    wd = in_data;
    wc = in_ctrl;
    d.oq = desc_dst_oq;
    d.len = desc_byte_len;
    d.src = desc_src_port;
    @(posedge clk);
    #1;
    if (reset) begin
      pending.delete();
      exp_q.delete();
      in_pkt = 0;
      hdr_age = 0;
      last_acc = 0;
      chk("rst_out_wr", 64'(out_wr), 64'(0));
      chk("rst_len_err", 64'(len_err), 64'(0));
      chk("rst_out_data", out_data, 64'(0));
      chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
      return;
    end
    if (dacc) pending.push_back(d);
    if (acc) begin
      pkt_cnt++;
      w.data = wd;
      w.ctrl = wc;
      w.err = (wc != 0) && ((pkt_cnt % 256) != pkt_words);
      exp_q.push_back(w);
      if (wc != 0) in_pkt = 0;
    end
    last_acc = acc;
    hdr_age++;
    if (out_wr) begin
      chk("out_wr_needs_rdy", 64'(rdy_at_edge), 64'(1));
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("pay_data", out_data, w.data);
        chk("pay_ctrl", 64'(out_ctrl), 64'(w.ctrl));
        chk("pay_len_err", 64'(len_err), 64'(w.err));
      end else if (!in_pkt && pending.size() > 0) begin
        d = pending.pop_front();
        chk("hdr_data", out_data, hdr_of(d));
        chk("hdr_ctrl", 64'(out_ctrl), 64'(IO_QUEUE_STAGE_NUM));
        chk("hdr_len_err", 64'(len_err), 64'(0));
        in_pkt = 1;
        hdr_age = 0;
        pkt_cnt = 0;
        pkt_words = words_of(d);
      end else begin
        chk("spurious_out_wr", 64'(out_wr), 64'(0));
      end
    end else begin
      chk("len_err_no_wr", 64'(len_err), 64'(0));
    end
  endtask

  task automatic write_desc(input int oq, input int len, input int src);
    desc_wr = 1'b1;
    desc_dst_oq = 3'(oq);
    desc_byte_len = 11'(len);
    desc_src_port = 16'(src);
    step();
    desc_wr = 1'b0;
  endtask

  // rdy_mode: 0 = out_rdy held 1, 1 = toggled every cycle, 2 = random
  task automatic send_pkt(input int n, input int rdy_mode, input bit gaps, input logic [7:0] eop);
    int idx = 0;
    int budget = 0;
    logic [7:0] m;
    while (idx < n && budget < 3000) begin
      in_data = {$urandom, $urandom};
      m = (eop != 0) ? eop : 8'($urandom);
      if (m == 0) m = 8'h01;
      in_ctrl = (idx == n - 1) ? m : 8'h00;
      in_wr = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: out_rdy = ~out_rdy;
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      step();
      if (last_acc) idx++;
      budget++;
    end
    if (idx < n) chk("pkt_timeout", 64'(idx), 64'(n));
    in_wr = 1'b0;
    in_ctrl = 8'h00;
    out_rdy = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    int idx;
    int len;
    int n;
    reset = 1'b1;
    desc_wr = 1'b0;
    desc_dst_oq = '0;
    desc_byte_len = '0;
    desc_src_port = '0;
    in_data = '0;
    in_ctrl = '0;
    in_wr = 1'b0;
    out_rdy = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    out_rdy = 1'b1;
    repeat (2) step();

    // Reference packet: header 0x0008_0008_0002_003C, 8 words, no error
    write_desc(3, 60, 2);
    send_pkt(8, 0, 0, 8'h08);

    // Single-word packet
    write_desc(0, 8, 5);
    send_pkt(1, 0, 0, 8'h80);

    // Short packet: 7 words against a 64-byte descriptor
    write_desc(1, 64, 7);
    send_pkt(7, 0, 1, 8'h00);

    // Zero byte length with a one-word packet
    write_desc(4, 0, 3);
    send_pkt(1, 0, 0, 8'h00);

    // Five descriptors while the output is stalled: the fifth is dropped
    out_rdy = 1'b0;
    write_desc(2, 16, 11);
    write_desc(5, 24, 12);
    write_desc(0, 8, 13);
    write_desc(1, 32, 14);
    write_desc(3, 40, 15);
    repeat (2) step();
    send_pkt(2, 0, 0, 8'h00);
    send_pkt(3, 0, 1, 8'h00);
    send_pkt(1, 2, 0, 8'h00);
    send_pkt(4, 2, 1, 8'h00);

    // out_rdy toggling every cycle during payload
    write_desc(2, 40, 9);
    send_pkt(5, 1, 0, 8'h00);

    // Destination queues outside the configured range
    write_desc(6, 16, 1);
    send_pkt(2, 0, 0, 8'h00);
    write_desc(7, 9, 1);
    send_pkt(2, 2, 0, 8'h00);

    // Reset in the middle of a packet, then leftover words must be ignored
    write_desc(5, 80, 4);
    idx = 0;
    n = 0;
    while (idx < 3 && n < 100) begin
      in_data = {$urandom, $urandom};
      in_ctrl = 8'h00;
      in_wr = 1'b1;
      out_rdy = 1'b1;
      step();
      if (last_acc) idx++;
      n++;
    end
    if (idx < 3) chk("rst_pkt_timeout", 64'(idx), 64'(3));
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) begin
      in_data = {$urandom, $urandom};
      step();
    end
    in_wr = 1'b0;
    write_desc(1, 24, 21);
    send_pkt(3, 0, 0, 8'h00);

    // Random packets, some with deliberately wrong word counts
    repeat (14) begin
      len = $urandom_range(0, 200);
      n = (len + 7) / 8;
      if (n == 0 || $urandom_range(0, 3) == 0) n = $urandom_range(1, 30);
      write_desc($urandom_range(0, 7), len, $urandom_range(0, 65535));
      send_pkt(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 8'h00);
    end

    chk("exp_words_left", 64'(exp_q.size()), 64'(0));
    chk("desc_left", 64'(pending.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
